// File: rtl/mem_arb_pkg.sv
// Shared definitions for the mem_arb_rr memory arbiter.
// Holds the arbitration mode encodings and the two-state FSM type.
package mem_arb_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner select: round-robin starting just after last_ptr,
// or fixed priority starting at index 0.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter  int COUNT = 4,
  localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic [COUNT-1:0] request,
  input  logic [IDX_W-1:0] last_ptr,
  input  logic             mode,
  output logic [COUNT-1:0] winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             found
);

  int               start;
  int               idx;
  logic [IDX_W-1:0] sel;

  // Walk all COUNT positions from the start point; the first requester seen wins.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    idx        = 0;
    sel        = '0;
    start      = (mode == MODE_RR) ? ((int'(last_ptr) + 1) % COUNT) : 0;
    for (int k = 0; k < COUNT; k++) begin
      idx = (start + k) % COUNT;
      sel = IDX_W'(idx);
      if (!found && request[sel]) begin
        found       = 1'b1;
        winner[sel] = 1'b1;
        winner_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/mem_arb_rr.sv
// Single-holder memory arbiter (round-robin or fixed priority) with an
// advisory yield request once a holder has used QUANTUM cycles under contention.
module mem_arb_rr
  import mem_arb_pkg::*;
#(
  parameter  int COUNT   = 4,
  parameter  int QUANTUM = 0,
  localparam int IDX_W   = (COUNT > 1) ? $clog2(COUNT) : 1,
  localparam int CNT_W   = (QUANTUM > 0) ? $clog2(QUANTUM + 1) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [COUNT-1:0] request,
  input  logic             mode,
  output logic [COUNT-1:0] authorized,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_index,
  output logic [COUNT-1:0] yield_req
);

  localparam logic             YIELD_EN = (QUANTUM > 0) && (COUNT > 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(QUANTUM);

  arb_state_e       state_q, state_d;
  logic [COUNT-1:0] authorized_q, authorized_d;
  logic             grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0] grant_index_q, grant_index_d;
  logic [COUNT-1:0] yield_q, yield_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] last_ptr_q, last_ptr_d;

  logic [IDX_W-1:0] pick_ptr;
  logic [COUNT-1:0] winner;
  logic [IDX_W-1:0] winner_idx;
  logic             found;
  logic             holder_req;
  logic             others_req;

  // During a grant the holder is the release pointer for a same-edge hand-over.
  assign pick_ptr   = (state_q == GRANT) ? grant_index_q : last_ptr_q;
  assign holder_req = |(request & authorized_q);
  assign others_req = |(request & ~authorized_q);

  rr_pick #(
    .COUNT(COUNT)
  ) u_pick (
    .request   (request),
    .last_ptr  (pick_ptr),
    .mode      (mode),
    .winner    (winner),
    .winner_idx(winner_idx),
    .found     (found)
  );

  always_comb begin
    state_d       = state_q;
    authorized_d  = authorized_q;
    grant_valid_d = grant_valid_q;
    grant_index_d = grant_index_q;
    yield_d       = yield_q;
    cnt_d         = cnt_q;
    last_ptr_d    = last_ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = GRANT;
          authorized_d  = winner;
          grant_valid_d = 1'b1;
          grant_index_d = winner_idx;
          cnt_d         = '0;
          yield_d       = '0;
        end
      end
      GRANT: begin
        if (holder_req) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          yield_d = (YIELD_EN && (cnt_q == CNT_MAX) && others_req) ? authorized_q : '0;
        end else begin
          last_ptr_d = grant_index_q;
          cnt_d      = '0;
          yield_d    = '0;
          if (found) begin
            authorized_d  = winner;
            grant_index_d = winner_idx;
          end else begin
            state_d       = IDLE;
            authorized_d  = '0;
            grant_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      authorized_q  <= '0;
      grant_valid_q <= 1'b0;
      grant_index_q <= '0;
      yield_q       <= '0;
      cnt_q         <= '0;
      last_ptr_q    <= IDX_W'(COUNT - 1);
    end else begin
      state_q       <= state_d;
      authorized_q  <= authorized_d;
      grant_valid_q <= grant_valid_d;
      grant_index_q <= grant_index_d;
      yield_q       <= yield_d;
      cnt_q         <= cnt_d;
      last_ptr_q    <= last_ptr_d;
    end
  end

  assign authorized  = authorized_q;
  assign grant_valid = grant_valid_q;
  assign grant_index = grant_index_q;
  assign yield_req   = yield_q;

endmodule

// File: doc/mem_arb_rr.md
MEM_ARB_RR -- requirements
Module: mem_arb_rr

Interface
REQ-001 SHALL have parameter COUNT, default 4, meaning number of requesting cores (1..32).
REQ-002 SHALL have parameter QUANTUM, default 0, meaning maximum grant cycles before a yield is requested; 0 means unlimited hold.
REQ-003 SHALL have localparam IDX_W = $clog2(COUNT) with a minimum of 1, meaning the grant index width.
REQ-004 SHALL have port clock  input  1  meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-006 SHALL have port request  input  COUNT  meaning per-core request; the core keeps it asserted for the whole memory use.
REQ-007 SHALL have port mode  input  1  meaning arbitration mode: 0 is round-robin, 1 is fixed priority with the lowest index winning.
REQ-008 SHALL have port authorized  output  COUNT  meaning one-hot or zero grant, registered.
REQ-009 SHALL have port grant_valid  output  1  meaning the OR of authorized, registered.
REQ-010 SHALL have port grant_index  output  IDX_W  meaning the binary index of the holder; it holds its last value when no core holds the grant.
REQ-011 SHALL have port yield_req  output  COUNT  meaning a one-hot request asking the holder to release, registered.

Function
REQ-012 SHALL implement two states: IDLE (no holder) and GRANT (one holder).
REQ-013 In IDLE with request non-zero, SHALL on the next edge enter GRANT with the authorized bit set for the winner; latency from request to authorized is 1 cycle.
REQ-014 In IDLE with request zero, SHALL remain in IDLE with authorized zero.
REQ-015 In round-robin mode, the winner SHALL be the first requesting index strictly after last_ptr, searching upward and wrapping from COUNT-1 to 0.
REQ-016 In fixed mode, the winner SHALL be the lowest requesting index, and last_ptr SHALL be ignored.
REQ-017 The arbiter SHALL sample mode only at an arbitration decision; a mode change during GRANT SHALL have no effect on the current holder.
REQ-018 In GRANT while request[holder] is 1, authorized SHALL remain unchanged whatever the other requests do.
REQ-019 In GRANT when request[holder] is 0, SHALL on the same edge re-arbitrate over request: grant the new winner and stay in GRANT, or clear authorized and go to IDLE if none is requesting; there SHALL be no dead cycle between holders.
REQ-020 On every release, last_ptr SHALL be updated to the index of the released holder.
REQ-021 The hold counter SHALL clear on each new grant, increment each GRANT cycle, and saturate at QUANTUM; its width SHALL be $clog2(QUANTUM+1), with a minimum of 1.
REQ-022 When QUANTUM>0, the counter equals QUANTUM, and any non-holder request is 1, yield_req[holder] SHALL assert on the next edge.
REQ-023 Once asserted, yield_req SHALL stay asserted until the holder drops its request.
REQ-024 yield_req SHALL clear on the same edge that authorized changes.
REQ-025 yield_req SHALL be advisory only: the arbiter SHALL never revoke authorized while request[holder] is 1.
REQ-026 If the other requesters withdraw while yield_req is asserted, yield_req SHALL deassert on the next edge, and the counter SHALL remain saturated.
REQ-027 With QUANTUM=0 or COUNT=1, yield_req SHALL be constant 0.
REQ-028 authorized SHALL never have more than one bit set, and any set bit SHALL be a bit of request as sampled on the granting edge.

Reset
REQ-029 While reset is high at a clock edge, the block SHALL load: state IDLE, authorized 0, grant_valid 0, grant_index 0, yield_req 0, counter 0, last_ptr COUNT-1 (so core 0 wins first).
REQ-030 Reset asserted mid-grant SHALL clear every output on that edge, regardless of request.
REQ-031 The first arbitration after reset is released SHALL follow REQ-013.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the mode encodings MODE_RR=0 and MODE_FIXED=1 and the state enum {IDLE, GRANT}.
REQ-033 Sub-module rr_pick, purely combinational and parametrised by COUNT, SHALL take request, last_ptr and mode, and return a one-hot winner plus its index.
REQ-034 The top level SHALL contain only the state register, the counter, last_ptr and the output registers.

Verification
REQ-035 The bench SHALL cover reset release with request=4'b1111 in mode 0 -> cycle 1 authorized=0001, grant_index=0, grant_valid=1.
REQ-036 The bench SHALL cover mode 0 with all four requesting, each holder dropping after 2 cycles -> grants 0001,0010,0100,1000,0001 in order with no gap cycles.
REQ-037 The bench SHALL cover mode 1 with request=1100, core 2 then dropping while core 3 holds and core 0 raises -> grants go 0100, then 0001 (lowest index), and core 3 is starved until core 0 releases.
REQ-038 The bench SHALL cover QUANTUM=8 with core 1 holding and core 3 raising at cycle 2 -> yield_req=0010 on hold cycle 9; core 1 ignores it for 5 cycles -> authorized stays 0010; core 1 drops -> next cycle authorized=1000 and yield_req=0000.
REQ-039 The bench SHALL cover reset asserted for 1 cycle during a grant with yield_req active -> all outputs 0 next cycle, and the next grant goes to core 0 first.
REQ-040 The bench SHALL check, on a random run of 10k cycles, that authorized is at most one-hot, that a grant is never revoked while the holder is requesting, and that no requester waits more than (COUNT-1) holder tenures in mode 0.
